// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide Hi/Lo block.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Widest value neg_n handles; callers widen into it and truncate the result back.
  localparam int NEG_MAX = 128;

  function automatic logic [NEG_MAX-1:0] neg_n(input logic [NEG_MAX-1:0] x, input int n);
    logic [NEG_MAX-1:0] mask;
    mask = (n >= NEG_MAX) ? '1 : ((NEG_MAX'(1) << n) - NEG_MAX'(1));
    return (~x + NEG_MAX'(1)) & mask;
  endfunction

endpackage

// File: rtl/muldiv_hilo_divu_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step, W steps per divide.
module divu_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] dsr;
  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W:0]   trial;

  // The dividend shifts out of quo_q's top while quotient bits shift in at the bottom.
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr   <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (load) begin
      dsr   <= divisor;
      rem_q <= '0;
      quo_q <= dividend;
    end else if (step) begin
      if (!trial[W]) rem_q <= trial[W-1:0];
      else           rem_q <= {rem_q[W-2:0], quo_q[W-1]};
      quo_q <= {quo_q[W-2:0], ~trial[W]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_hilo.sv
// Hi/Lo register pair with an iterative shift-add multiplier and restoring divider.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter  int W  = 32,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  input  logic         ren,
  input  logic         is_hi,
  output logic [W-1:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         stall,
  output state_e       dbg_state
);

  // Handshake: start/mthi/mtlo are consumed on any rising edge where busy is low;
  // while busy they are dropped and stall asks EX to hold and re-present them.

  state_e         state;
  logic [CW-1:0]  count;
  logic [W-1:0]   hi, lo, a_orig, mplier;
  logic [2*W-1:0] mcand, acc;
  logic           op_div, sign_q, sign_r, dbz;

  logic           is_signed;
  logic [W-1:0]   mag_a, mag_b;
  logic [W-1:0]   quo, rem, quo_fix, rem_fix;
  logic [2*W-1:0] prod_fix;
  logic           div_load, div_step;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (is_signed && a[W-1]) ? W'(neg_n(NEG_MAX'(a), W)) : a;
    mag_b     = (is_signed && b[W-1]) ? W'(neg_n(NEG_MAX'(b), W)) : b;
    prod_fix  = sign_q ? (2*W)'(neg_n(NEG_MAX'(acc), 2*W)) : acc;
    quo_fix   = sign_q ? W'(neg_n(NEG_MAX'(quo), W)) : quo;
    rem_fix   = sign_r ? W'(neg_n(NEG_MAX'(rem), W)) : rem;
    div_load  = (state == IDLE) && start && op[1];
    div_step  = (state == ITER) && op_div;
  end

  divu_iter #(.W(W)) u_divu_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      a_orig      <= '0;
      mplier      <= '0;
      mcand       <= '0;
      acc         <= '0;
      op_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state  <= ITER;
            count  <= '0;
            a_orig <= a;
            op_div <= op[1];
            sign_q <= is_signed & (a[W-1] ^ b[W-1]);
            sign_r <= is_signed & a[W-1];
            dbz    <= op[1] && (b == '0);
            mcand  <= {{W{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
          end
        end
        ITER: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (dbz) begin
            hi <= a_orig;
            lo <= '1;
          end else if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done        <= 1'b1;
          div_by_zero <= dbz;
          count       <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stall     = busy & (ren | mthi | mtlo | start);
  assign rdata     = !ren ? '0 : (is_hi ? hi : lo);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: vector table, random ops against an arithmetic model, corner sequences.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int CKW = 2 * W + 1;

  logic         clk, rst_n, start, mthi, mtlo, ren, is_hi;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, rdata;
  logic         busy, done, div_by_zero, stall;
  state_e       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [CKW-1:0] exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz;
  } vec_t;
  vec_t vecs[11];

  muldiv_hilo #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .ren         (ren),
    .is_hi       (is_hi),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .stall       (stall),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [CKW-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sp;
    logic signed [W-1:0]   q, r;
    logic [2*W-1:0]        up;
    case (o)
      OP_MULT: begin
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        sp = sx * sy;
        return {1'b0, sp};
      end
      OP_MULTU: begin
        up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return {1'b0, up};
      end
      OP_DIV: begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {1'b0, r, q};
      end
      default: return {1'b0, x % y, x / y};
    endcase
  endfunction

  // Drive start for one edge and record what the result must be.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [CKW-1:0] expv);
    start = 1'b1; op = o; a = av; b = bv;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until done, then compare Hi/Lo/div_by_zero with the queue head.
  task automatic wait_done(input int pre_busy);
    int n = pre_busy;
    int cyc = 0;
    int early = 0;
    logic [CKW-1:0] e;
    logic [W-1:0] rh, rl;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) n++;
      if (div_by_zero === 1'b1) early++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", CKW'(done), CKW'(1));
    check("busy_cycles", CKW'(n), CKW'(W + 1));
    check("dbz_before_done", CKW'(early), CKW'(0));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", CKW'(0), CKW'(1));
      end else begin
        e = exp_q.pop_front();
        ren = 1'b1; is_hi = 1'b1; #1 rh = rdata;
        is_hi = 1'b0; #1 rl = rdata;
        ren = 1'b0;
        check("hi", CKW'(rh), CKW'(e[2*W-1:W]));
        check("lo", CKW'(rl), CKW'(e[W-1:0]));
        check("dbz", CKW'(div_by_zero), CKW'(e[2*W]));
      end
    end
  endtask

  initial begin
    int nd;
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; ren = 1'b0; is_hi = 1'b0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

    repeat (2) @(negedge clk);
    ren = 1'b1; is_hi = 1'b1; #1;
    check("rst_busy", CKW'(busy), CKW'(0));
    check("rst_done", CKW'(done), CKW'(0));
    check("rst_dbz", CKW'(div_by_zero), CKW'(0));
    check("rst_stall", CKW'(stall), CKW'(0));
    check("rst_state", CKW'(dbg_state), CKW'(IDLE));
    check("rst_hi", CKW'(rdata), CKW'(0));
    is_hi = 1'b0; #1;
    check("rst_lo", CKW'(rdata), CKW'(0));
    ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each start is driven in the previous op's done cycle.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].hi, vecs[i].lo});
      wait_done(0);
    end
    ren = 1'b0; is_hi = 1'b0; #1;
    check("rdata_no_ren", CKW'(rdata), CKW'(0));
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 1) == 1) ry = W'($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) rx = -W'($urandom_range(1, 1000));
      if (ry == '0) ry = W'(1);
      if (ro == OP_DIV && ry == '1) ry = W'(3);
      issue(ro, rx, ry, model(ro, rx, ry));
      wait_done(0);
    end
    @(negedge clk);

    // Events while busy are stalled and dropped.
    mtlo = 1'b1; wdata = 32'h0BAD0BAD;
    @(negedge clk);
    mtlo = 1'b0;
    ren = 1'b1; is_hi = 1'b0; #1;
    check("mtlo_idle", CKW'(rdata), CKW'(32'h0BAD0BAD));
    ren = 1'b0;
    issue(OP_MULTU, 32'd5, 32'd6, {1'b0, 32'd0, 32'd30});
    ren = 1'b1; is_hi = 1'b0; #1;
    check("stall_ren", CKW'(stall), CKW'(1));
    check("rd_old_lo", CKW'(rdata), CKW'(32'h0BAD0BAD));
    ren = 1'b0;
    mtlo = 1'b1; wdata = 32'h1234; #1;
    check("stall_mtlo", CKW'(stall), CKW'(1));
    @(negedge clk);
    mtlo = 1'b0;
    ren = 1'b1; #1;
    check("mtlo_dropped", CKW'(rdata), CKW'(32'h0BAD0BAD));
    ren = 1'b0;
    start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1; #1;
    check("stall_start", CKW'(stall), CKW'(1));
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    @(negedge clk);
    check("start_not_queued", CKW'(busy), CKW'(0));

    // mthi together with start in IDLE: write lands now, result overwrites later.
    mthi = 1'b1; wdata = 32'hAAAA5555;
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    exp_q.push_back({1'b0, 32'd0, 32'd6});
    @(negedge clk);
    mthi = 1'b0; start = 1'b0;
    ren = 1'b1; is_hi = 1'b1; #1;
    check("mthi_with_start", CKW'(rdata), CKW'(32'hAAAA5555));
    check("busy_after_start", CKW'(busy), CKW'(1));
    ren = 1'b0;
    wait_done(0);
    @(negedge clk);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    ren = 1'b1; is_hi = 1'b1; #1;
    check("both_hi", CKW'(rdata), CKW'(32'h77));
    is_hi = 1'b0; #1;
    check("both_lo", CKW'(rdata), CKW'(32'h77));
    ren = 1'b0;

    // Reset mid-operation abandons it.
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", CKW'(busy), CKW'(0));
    check("mid_rst_done", CKW'(done), CKW'(0));
    ren = 1'b1; is_hi = 1'b1; #1;
    check("mid_rst_hi", CKW'(rdata), CKW'(0));
    is_hi = 1'b0; #1;
    check("mid_rst_lo", CKW'(rdata), CKW'(0));
    ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("no_late_done", CKW'(nd), CKW'(0));
    ren = 1'b1; is_hi = 1'b0; #1;
    check("no_late_write", CKW'(rdata), CKW'(0));
    ren = 1'b0;
    check("sb_empty", CKW'(exp_q.size()), CKW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
